// File: rtl/tile_match_engine_if.sv
// Board-load port for tile_match_engine: one symbol per cycle under valid/ready.
interface tile_match_engine_if #(
  parameter int unsigned SYM_W = 3
) ();
  logic             ld_valid;
  logic [SYM_W-1:0] ld_sym;
  logic             ld_ready;

  modport master (output ld_valid, output ld_sym, input ld_ready);
  modport slave  (input ld_valid, input ld_sym, output ld_ready);
endinterface

// File: rtl/tile_match_engine.sv
// Tile-matching game core: board load, button conditioning, pick/compare/show/done
// sequencing with score, miss counting and win/lose decision.
module tile_match_engine #(
  parameter int unsigned NUM_TILES   = 16,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned SYM_W       = 3,
  parameter int unsigned SHOW_CYCLES = 50_000_000,
  parameter int unsigned MAX_MISSES  = 0
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [2:0]           KEY,
  input  logic [IDX_W-1:0]     SW,
  tile_match_engine_if.slave   ld,
  output logic [NUM_TILES-1:0] reveal_mask,
  output logic [SYM_W-1:0]     first_sym,
  output logic [SYM_W-1:0]     second_sym,
  output logic [IDX_W-1:0]     score,
  output logic [7:0]           misses,
  output logic [2:0]           state,
  output logic                 done,
  output logic                 win,
  output logic                 err
);

  localparam int unsigned TimerW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(SHOW_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LastIdx   = IDX_W'(NUM_TILES - 1);
  localparam logic [IDX_W:0]    AllPairs  = (IDX_W + 1)'(NUM_TILES / 2);

  typedef enum logic [2:0] {
    StLoad    = 3'd0,
    StPick1   = 3'd1,
    StPick2   = 3'd2,
    StCompare = 3'd3,
    StShow    = 3'd4,
    StDone    = 3'd5
  } state_e;

  state_e                state_q;
  logic [SYM_W-1:0]      board_q [NUM_TILES];
  logic [IDX_W-1:0]      wr_ptr_q;
  logic [NUM_TILES-1:0]  matched_q;
  logic [IDX_W-1:0]      first_q, second_q;
  logic                  first_vld_q, second_vld_q;
  logic [SYM_W-1:0]      first_sym_q, second_sym_q;
  logic [TimerW-1:0]     timer_q;
  logic [IDX_W-1:0]      score_q;
  logic [7:0]            misses_q;
  logic                  win_q, err_q;
  logic [2:0]            key_s1_q, key_s2_q, key_prev_q;

  logic [2:0]            press;
  logic                  sw_ok;
  logic [IDX_W:0]        score_inc;
  logic [7:0]            miss_inc;

  // Falling edge of the synchronised, active-low button.
  assign press     = ~key_s2_q & key_prev_q;
  assign sw_ok     = (32'(SW) < NUM_TILES) && !matched_q[SW];
  assign score_inc = {1'b0, score_q} + 1'b1;
  assign miss_inc  = (misses_q == 8'hFF) ? 8'hFF : misses_q + 8'd1;

  always_ff @(posedge CLOCK_50) begin
    if (resetn && (state_q == StLoad) && ld.ld_valid) begin
      board_q[wr_ptr_q] <= ld.ld_sym;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q      <= StLoad;
      wr_ptr_q     <= '0;
      matched_q    <= '0;
      first_q      <= '0;
      second_q     <= '0;
      first_vld_q  <= 1'b0;
      second_vld_q <= 1'b0;
      first_sym_q  <= '0;
      second_sym_q <= '0;
      timer_q      <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      win_q        <= 1'b0;
      err_q        <= 1'b0;
      key_s1_q     <= 3'b111;
      key_s2_q     <= 3'b111;
      key_prev_q   <= 3'b111;
    end else begin
      key_s1_q   <= KEY;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
      err_q      <= 1'b0;

      case (state_q)
        StLoad: begin
          if (ld.ld_valid) begin
            if (wr_ptr_q == LastIdx) begin
              wr_ptr_q     <= '0;
              matched_q    <= '0;
              score_q      <= '0;
              misses_q     <= '0;
              win_q        <= 1'b0;
              first_vld_q  <= 1'b0;
              second_vld_q <= 1'b0;
              first_sym_q  <= '0;
              second_sym_q <= '0;
              state_q      <= StPick1;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
          end
        end

        StPick1, StPick2: begin
          if (press[2]) begin
            first_vld_q  <= 1'b0;
            second_vld_q <= 1'b0;
            first_sym_q  <= '0;
            second_sym_q <= '0;
            wr_ptr_q     <= '0;
            state_q      <= StLoad;
          end else if (press[0]) begin
            if (state_q == StPick1 && sw_ok) begin
              first_q     <= SW;
              first_vld_q <= 1'b1;
              first_sym_q <= board_q[SW];
              state_q     <= StPick2;
            end else if (state_q == StPick2 && sw_ok && (SW != first_q)) begin
              second_q     <= SW;
              second_vld_q <= 1'b1;
              second_sym_q <= board_q[SW];
              state_q      <= StCompare;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        StCompare: begin
          if (first_sym_q == second_sym_q) begin
            matched_q[first_q]  <= 1'b1;
            matched_q[second_q] <= 1'b1;
            score_q      <= score_inc[IDX_W-1:0];
            first_vld_q  <= 1'b0;
            second_vld_q <= 1'b0;
            first_sym_q  <= '0;
            second_sym_q <= '0;
            if (score_inc == AllPairs) begin
              win_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StPick1;
            end
          end else begin
            misses_q <= miss_inc;
            if ((MAX_MISSES != 0) && (32'(miss_inc) >= MAX_MISSES)) begin
              win_q   <= 1'b0;
              state_q <= StDone;
            end else begin
              timer_q <= TimerLoad;
              state_q <= StShow;
            end
          end
        end

        StShow: begin
          if (press[2] || press[1] || (timer_q == '0)) begin
            first_vld_q  <= 1'b0;
            second_vld_q <= 1'b0;
            first_sym_q  <= '0;
            second_sym_q <= '0;
            wr_ptr_q     <= '0;
            state_q      <= press[2] ? StLoad : StPick1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        StDone: begin
          if (press[2]) begin
            wr_ptr_q <= '0;
            state_q  <= StLoad;
          end
        end

        default: state_q <= StLoad;
      endcase
    end
  end

  always_comb begin
    reveal_mask = matched_q;
    if (first_vld_q)  reveal_mask[first_q]  = 1'b1;
    if (second_vld_q) reveal_mask[second_q] = 1'b1;
  end

  assign ld.ld_ready = (state_q == StLoad);
  assign first_sym   = first_sym_q;
  assign second_sym  = second_sym_q;
  assign score       = score_q;
  assign misses      = misses_q;
  assign state       = state_q;
  assign done        = (state_q == StDone);
  assign win         = win_q;
  assign err         = err_q;

endmodule

// File: tb/tb_tile_match_engine.sv
// Scoreboard bench for tile_match_engine: directed game scenarios push expected
// outputs tagged with a cycle; a negedge monitor pops and compares them.
module tb_tile_match_engine;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] key = 3'b111;
  logic [1:0] sw = 2'd0;

  logic [3:0] reveal_mask;
  logic [1:0] first_sym, second_sym, score;
  logic [7:0] misses;
  logic [2:0] state;
  logic       done, win, err;

  tile_match_engine_if #(.SYM_W(2)) ld_if ();

  tile_match_engine #(
    .NUM_TILES  (4),
    .IDX_W      (2),
    .SYM_W      (2),
    .SHOW_CYCLES(8),
    .MAX_MISSES (2)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .KEY        (key),
    .SW         (sw),
    .ld         (ld_if.slave),
    .reveal_mask(reveal_mask),
    .first_sym  (first_sym),
    .second_sym (second_sym),
    .score      (score),
    .misses     (misses),
    .state      (state),
    .done       (done),
    .win        (win),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    string name;
    int    sel;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int sel);
    case (sel)
      0:       return int'(ld_if.ld_ready);
      1:       return int'(reveal_mask);
      2:       return int'(first_sym);
      3:       return int'(second_sym);
      4:       return int'(score);
      5:       return int'(misses);
      6:       return int'(state);
      7:       return int'(done);
      8:       return int'(win);
      default: return int'(err);
    endcase
  endfunction

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = actual(e.sel);
      n_cmp++;
      if (e.cyc != cyc || a != e.val) begin
        n_bad++;
        $display("FAIL %s: cycle %0d (due %0d) got %0d required %0d", e.name, cyc, e.cyc, a,
                 e.val);
      end
    end
  end

  task automatic sb_push(input int ofs, input string name, input int sel, input int val);
    exp_t e;
    e.cyc  = cyc + ofs;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle low pulse; returns just after the edge at which the press acts.
  task automatic press(input int k);
    key[k] = 1'b0;
    tick();
    key[k] = 1'b1;
    tick();
    tick();
  endtask

  task automatic pick(input int idx);
    sw = 2'(idx);
    press(0);
  endtask

  task automatic load4(input int a, input int b, input int c, input int d);
    int w[4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    sb_push(0, "ld_ready_pre", 0, 1);
    for (int i = 0; i < 4; i++) begin
      ld_if.ld_valid = 1'b1;
      ld_if.ld_sym   = 2'(w[i]);
      tick();
    end
    ld_if.ld_valid = 1'b0;
    sb_push(0, "load_state", 6, 1);
    sb_push(0, "load_ready", 0, 0);
    sb_push(0, "load_score", 4, 0);
    sb_push(0, "load_reveal", 1, 0);
  endtask

  task automatic expect_reset(input int ofs);
    sb_push(ofs, "rst_ready", 0, 1);
    sb_push(ofs, "rst_reveal", 1, 0);
    sb_push(ofs, "rst_first", 2, 0);
    sb_push(ofs, "rst_second", 3, 0);
    sb_push(ofs, "rst_score", 4, 0);
    sb_push(ofs, "rst_misses", 5, 0);
    sb_push(ofs, "rst_state", 6, 0);
    sb_push(ofs, "rst_done", 7, 0);
    sb_push(ofs, "rst_win", 8, 0);
    sb_push(ofs, "rst_err", 9, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ld_if.ld_valid = 1'b0;
    ld_if.ld_sym   = 2'd0;

    // Reset and first load
    tick();
    tick();
    n_cmp++;
    if (state !== 3'd0 || ld_if.ld_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL direct_rst: state %0d ld_ready %0b", state, ld_if.ld_ready);
    end
    expect_reset(0);
    resetn = 1'b1;
    load4(1, 2, 1, 2);
    n_cmp++;
    if (state !== 3'd1 || ld_if.ld_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_load: state %0d ld_ready %0b", state, ld_if.ld_ready);
    end

    // Match 0/2
    pick(0);
    sb_push(0, "p1_state", 6, 2);
    sb_push(0, "p1_first_sym", 2, 1);
    sb_push(0, "p1_reveal", 1, 4'b0001);
    pick(2);
    sb_push(0, "cmp_state", 6, 3);
    sb_push(0, "cmp_second_sym", 3, 1);
    sb_push(0, "cmp_reveal", 1, 4'b0101);
    sb_push(1, "match_state", 6, 1);
    sb_push(1, "match_score", 4, 1);
    sb_push(1, "match_reveal", 1, 4'b0101);
    sb_push(1, "match_first_clr", 2, 0);

    // Rejected picks
    pick(0);
    sb_push(0, "rej1_err", 9, 1);
    sb_push(0, "rej1_state", 6, 1);
    sb_push(1, "rej1_err_drop", 9, 0);
    pick(1);
    sb_push(0, "p1b_state", 6, 2);
    sb_push(0, "p1b_first_sym", 2, 2);
    pick(1);
    sb_push(0, "rej2_err", 9, 1);
    sb_push(0, "rej2_state", 6, 2);
    press(2);
    sb_push(0, "restart_state", 6, 0);
    sb_push(0, "restart_reveal", 1, 4'b0101);

    // Mismatch with full SHOW period
    load4(0, 1, 1, 0);
    pick(0);
    pick(1);
    sb_push(0, "mm_cmp_state", 6, 3);
    sb_push(1, "mm_misses", 5, 1);
    for (int i = 1; i <= 8; i++) begin
      sb_push(i, "show_reveal", 1, 4'b0011);
      sb_push(i, "show_state", 6, 4);
    end
    sb_push(9, "show_end_reveal", 1, 4'b0000);
    sb_push(9, "show_end_state", 6, 1);
    repeat (9) tick();

    // Mismatch skipped with KEY[1]
    press(2);
    sb_push(0, "restart2_state", 6, 0);
    load4(0, 1, 1, 0);
    pick(0);
    pick(1);
    sb_push(1, "skip_show1", 6, 4);
    sb_push(2, "skip_show2", 6, 4);
    sb_push(3, "skip_state", 6, 1);
    sb_push(3, "skip_reveal", 1, 4'b0000);
    press(1);

    // Second mismatch loses
    pick(0);
    pick(1);
    sb_push(1, "loss_state", 6, 5);
    sb_push(1, "loss_done", 7, 1);
    sb_push(1, "loss_win", 8, 0);
    sb_push(1, "loss_misses", 5, 2);
    tick();
    press(2);
    sb_push(0, "newgame_state", 6, 0);
    sb_push(0, "newgame_done", 7, 0);

    // Win
    load4(1, 2, 1, 2);
    pick(0);
    pick(2);
    sb_push(1, "win_p1_score", 4, 1);
    tick();
    pick(1);
    pick(3);
    sb_push(1, "win_state", 6, 5);
    sb_push(1, "win_flag", 8, 1);
    sb_push(1, "win_score", 4, 2);
    sb_push(1, "win_done", 7, 1);
    sb_push(1, "win_reveal", 1, 4'b1111);
    tick();

    // Reset during SHOW
    press(2);
    load4(0, 1, 1, 0);
    pick(0);
    pick(1);
    sb_push(1, "pre_rst_state", 6, 4);
    sb_push(1, "pre_rst_misses", 5, 1);
    tick();
    resetn = 1'b0;
    tick();
    expect_reset(0);
    resetn = 1'b1;

    // Held KEY[0] gives exactly one pick
    load4(0, 1, 1, 0);
    sw     = 2'd0;
    key[0] = 1'b0;
    repeat (3) tick();
    sb_push(0, "hold_state", 6, 2);
    sb_push(0, "hold_reveal", 1, 4'b0001);
    sw = 2'd1;
    repeat (17) tick();
    sb_push(0, "hold_state_end", 6, 2);
    sb_push(0, "hold_err", 9, 0);
    sb_push(0, "hold_reveal_end", 1, 4'b0001);
    key[0] = 1'b1;
    repeat (3) tick();
    sb_push(0, "release_state", 6, 2);
    n_cmp++;
    if (state !== 3'd2) begin
      n_bad++;
      $display("FAIL direct_release: state %0d", state);
    end

    repeat (3) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never compared, due cycle %0d required %0d", e.name, e.cyc, e.val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
